// File: rtl/pixel_coord_gen.sv
// Raster x/y/enable generator from camera vsync/data-valid, pixel data aligned.
// Optional geometry checker: define PIXEL_COORD_GEN_FRAME_ERR_EN.
module pixel_coord_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PIX_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic [PIX_W-1:0] pix_in,
  output logic [10:0]      gr_x,
  output logic [9:0]       gr_y,
  output logic             en,
  output logic [PIX_W-1:0] pix_out,
  output logic             sof,
  output logic [15:0]      frame_cnt,
  output logic             frame_err
);

  localparam int XW = 11;
  localparam int YW = 10;
  localparam logic [XW-1:0] H_X = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_Y = YW'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SYNC,
    S_ACTIVE
  } state_e;

  state_e          state_q;
  logic            vs_q;
  logic            de_q;
  logic            first_q;
  logic [XW-1:0]   x_cnt_q;
  logic [YW-1:0]   y_cnt_q;
  logic [XW-1:0]   gx_q;
  logic [YW-1:0]   gy_q;
  logic            en_q;
  logic            sof_q;
  logic [PIX_W-1:0] pix_q;
  logic [15:0]     fcnt_q;

  logic vs_rise;
  logic de_fall;
  logic active;
  logic en_d;
  logic line_end;

  always_comb begin
    vs_rise  = vs_in & ~vs_q;
    de_fall  = ~de_in & de_q;
    active   = (state_q == S_ACTIVE);
    en_d     = active & ~vs_rise & de_in &
               (x_cnt_q < H_X) & (y_cnt_q < V_Y);
    // a fall only closes a line that actually counted pixels in ACTIVE
    line_end = active & ~vs_rise & de_fall & (x_cnt_q != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      first_q <= 1'b0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      en_q    <= 1'b0;
      sof_q   <= 1'b0;
      pix_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      vs_q  <= vs_in;
      de_q  <= de_in;
      pix_q <= pix_in;
      en_q  <= en_d;
      sof_q <= en_d & first_q;
      if (en_d) begin
        gx_q    <= x_cnt_q;
        gy_q    <= y_cnt_q;
        first_q <= 1'b0;
      end
      if (vs_rise)
        fcnt_q <= fcnt_q + 16'd1;
      unique case (state_q)
        S_WAIT: begin
          if (vs_rise)
            state_q <= S_SYNC;
        end
        S_SYNC: begin
          x_cnt_q <= '0;
          y_cnt_q <= '0;
          first_q <= 1'b1;
          if (!vs_in)
            state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            state_q <= S_SYNC;
          end else if (line_end) begin
            x_cnt_q <= '0;
            if (y_cnt_q < V_Y)
              y_cnt_q <= y_cnt_q + YW'(1);
          end else if (de_in && (x_cnt_q < H_X)) begin
            x_cnt_q <= x_cnt_q + XW'(1);
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

`ifdef PIXEL_COORD_GEN_FRAME_ERR_EN
  logic line_err_q;
  logic x_ovf_q;
  logic ferr_q;

  // x_cnt saturates at H_ACTIVE, so over-long lines need their own flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_err_q <= 1'b0;
      x_ovf_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (active) begin
      if (vs_rise) begin
        ferr_q     <= line_err_q | (y_cnt_q != V_Y);
        line_err_q <= 1'b0;
        x_ovf_q    <= 1'b0;
      end else if (line_end) begin
        if ((x_cnt_q != H_X) || x_ovf_q)
          line_err_q <= 1'b1;
        x_ovf_q <= 1'b0;
      end else if (de_in && (x_cnt_q == H_X)) begin
        x_ovf_q <= 1'b1;
      end
    end else begin
      x_ovf_q <= 1'b0;
    end
  end

  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign gr_x      = gx_q;
  assign gr_y      = gy_q;
  assign en        = en_q;
  assign pix_out   = pix_q;
  assign sof       = sof_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Directed bench for pixel_coord_gen at H_ACTIVE=8, V_ACTIVE=4.
// Expected frame_err follows PIXEL_COORD_GEN_FRAME_ERR_EN.
module tb_pixel_coord_gen;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int PW = 8;
`ifdef PIXEL_COORD_GEN_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vs_in = 1'b0;
  logic          de_in = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic [10:0]   gr_x;
  logic [9:0]    gr_y;
  logic          en;
  logic [PW-1:0] pix_out;
  logic          sof;
  logic [15:0]   frame_cnt;
  logic          frame_err;

  int checks = 0;
  int failures = 0;
  int exp_gx = 0;
  int exp_gy = 0;

  pixel_coord_gen #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .PIX_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vs_in(vs_in),
    .de_in(de_in),
    .pix_in(pix_in),
    .gr_x(gr_x),
    .gr_y(gr_y),
    .en(en),
    .pix_out(pix_out),
    .sof(sof),
    .frame_cnt(frame_cnt),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int p, input int y, input bit valid);
    bit exp_en;
    de_in  = 1'b1;
    pix_in = 8'(y * 16 + p);
    step();
    exp_en = valid && (p < H) && (y < V);
    if (exp_en) begin
      exp_gx = p;
      exp_gy = y;
    end
    chk("en", en, exp_en);
    chk("gr_x", gr_x, exp_gx);
    chk("gr_y", gr_y, exp_gy);
    chk("sof", sof, exp_en && p == 0 && y == 0);
    chk("pix_out", pix_out, pix_in);
  endtask

  task automatic send_line(input int npix, input int y, input bit valid);
    for (int p = 0; p < npix; p++)
      pixel(p, y, valid);
    de_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("gap_en", en, 0);
    end
  endtask

  task automatic vs_pulse(input int exp_cnt, input bit exp_err);
    vs_in = 1'b1;
    de_in = 1'b0;
    step();
    chk("vs_en", en, 0);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("frame_err", frame_err, exp_err);
    vs_in = 1'b0;
    step();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_gr_x"}, gr_x, 0);
    chk({tag, "_gr_y"}, gr_y, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_pix"}, pix_out, 0);
    chk({tag, "_fcnt"}, frame_cnt, 0);
    chk({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    pix_in = 8'hA5;
    repeat (2) step();
    chk_reset_outs("rst");
    reset = 1'b1;
    pix_in = '0;
    step();

    // bursts before any vsync: nothing output, no frames
    send_line(8, 0, 1'b0);
    send_line(8, 1, 1'b0);
    chk("pre_vs_fcnt", frame_cnt, 0);

    // normal frame
    vs_pulse(1, 1'b0);
    for (int y = 0; y < V; y++)
      send_line(8, y, 1'b1);
    chk("f1_fcnt", frame_cnt, 1);
    chk("f1_ferr", frame_err, 0);

    // over-long line 1
    vs_pulse(2, 1'b0);
    send_line(8, 0, 1'b1);
    send_line(10, 1, 1'b1);
    send_line(8, 2, 1'b1);
    send_line(8, 3, 1'b1);

    // six lines; last two suppressed
    vs_pulse(3, ERR_EN);
    for (int y = 0; y < 6; y++)
      send_line(8, y, 1'b1);

    // vsync aborts line 2 at pixel 5
    vs_pulse(4, 1'b0);
    send_line(8, 0, 1'b1);
    send_line(8, 1, 1'b1);
    for (int p = 0; p < 5; p++)
      pixel(p, 2, 1'b1);
    vs_in = 1'b1;
    de_in = 1'b1;
    step();
    chk("abort_en", en, 0);
    chk("abort_gr_x", gr_x, 4);
    chk("abort_gr_y", gr_y, 2);
    chk("abort_fcnt", frame_cnt, 5);
    chk("abort_ferr", frame_err, ERR_EN);
    vs_in = 1'b0;
    de_in = 1'b0;
    step();
    send_line(8, 0, 1'b1);

    // async reset mid-line
    for (int p = 0; p < 3; p++)
      pixel(p, 1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    exp_gx = 0;
    exp_gy = 0;
    chk_reset_outs("mid_rst");
    de_in = 1'b0;
    pix_in = '0;
    step();
    reset = 1'b1;
    send_line(8, 0, 1'b0);
    chk("post_rst_fcnt", frame_cnt, 0);
    vs_pulse(1, 1'b0);
    send_line(8, 0, 1'b1);
    send_line(8, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
